verin_ctrl: RTL
===============

Name: verin_ctrl

Overview:
- Closed-loop sequencer for the tiller actuator (vérin).
- Accepts a target tiller angle via a valid/ready command port and compares it with the measured angle_barre.
- Drives the motor bridge with a PWM signal plus a direction line (sens), using the freq/duty settings written by the processor.
- Enforces the left/right end stops (butee_g/butee_d), inserts a dead time on every direction change, and reports status back to the SOPC.

Parameters:
- ANGLE_W, 12, width of angle, target and end-stop values (unsigned).
- PWM_W, 16, width of freq (PWM period in clk cycles) and duty (high time in clk cycles).
- HYST, 4, dead band in LSBs around the target.
- DEADTIME, 50, clk cycles with pwm=0 before sens may toggle.
- RAMP_STEP, 16, duty increment per PWM period (soft start only).

Ports:
- clk  in  1  system clock.
- raz_n  in  1  reset, synchronous, active-low.
- enable  in  1  1 = regulation allowed; 0 = forced stop.
- cmd_valid  in  1  new target present.
- cmd_ready  out  1  target can be accepted this cycle.
- cmd_target  in  ANGLE_W  requested angle.
- angle_barre  in  ANGLE_W  measured tiller angle.
- butee_g  in  ANGLE_W  left (low) end stop.
- butee_d  in  ANGLE_W  right (high) end stop.
- freq  in  PWM_W  PWM period in clk cycles.
- duty  in  PWM_W  PWM high time in clk cycles.
- pwm  out  1  bridge PWM.
- sens  out  1  1 = drive toward increasing angle, 0 = decreasing.
- at_target  out  1  |angle-target| <= HYST while IDLE.
- limit_hit  out  1  sticky: a drive was stopped by an end stop; cleared by the next accepted command.
- cfg_err  out  1  butee_g >= butee_d.
- state  out  2  0 IDLE, 1 DRIVE_INC, 2 DRIVE_DEC, 3 DEAD.

Behaviour:
- Reset (raz_n=0 at a clk edge):
  - state=IDLE, pwm=0, sens=0, at_target=0, limit_hit=0, cmd_ready=0.
  - target register = 0, PWM counter = 0, dead counter = 0.
  - Reset mid-drive cuts pwm on the same edge.
- Command handshake:
  - cmd_ready=1 in IDLE, DRIVE_INC and DRIVE_DEC; 0 in DEAD, while in reset, and while cfg_err=1.
  - On cmd_valid&&cmd_ready, the target is latched, clamped to [butee_g, butee_d], and used from the next cycle. limit_hit is cleared.
  - Once a command is accepted, the bench holds cmd_valid low at least one cycle before the next one.
- cfg_err is combinational from butee_g/butee_d. While cfg_err=1: state is forced to IDLE and pwm=0.
- enable=0: state goes to IDLE on the next edge and pwm=0 from that edge. sens is held.
- Comparisons use registered err = target - angle_barre (signed, ANGLE_W+1 bits).
- IDLE:
  - err > HYST: want INC. err < -HYST: want DEC.
  - If the wanted direction equals sens, go to DRIVE_x. Otherwise go to DEAD, then sens toggles and the block enters DRIVE_x.
  - No end-stop check is done in IDLE; it applies from DRIVE entry.
- DRIVE_INC:
  - Leave to IDLE when angle_barre >= target.
  - Leave to IDLE and set limit_hit when angle_barre >= butee_d. The end stop has priority if both happen on the same cycle.
  - If err < -HYST (new target behind), go to DEAD.
- DRIVE_DEC: mirror of DRIVE_INC with butee_g and <=.
- DEAD:
  - pwm=0; the counter counts DEADTIME cycles.
  - On the last cycle, sens toggles and the block enters the pending DRIVE direction.
  - If the pending direction is no longer needed (|err| <= HYST), it returns to IDLE without toggling sens.
- PWM:
  - The counter runs 0..freq-1 and wraps. It restarts at 0 on every DRIVE entry.
  - pwm = (cnt < duty_eff) in DRIVE states only. The first high cycle is the cycle after entry.
  - freq=0 gives pwm=0. duty >= freq gives 100%. duty=0 gives pwm=0.
  - freq and duty are sampled at the counter wrap.
- at_target: registered; 1 only in IDLE with |err| <= HYST.

Optional Feature:
- VERIN_SOFT_START_EN defined:
  - duty_eff resets to 0 on every DRIVE entry.
  - It increases by RAMP_STEP at each PWM period wrap, saturating at duty.
- Not defined: duty_eff = duty immediately. RAMP_STEP is unused.

Test Plan:
- Reset with raz_n=0 and all inputs active -> pwm=0, sens=0, state=0, cmd_ready=0. One cycle after raz_n=1: cmd_ready=1.
- Setup: butee_g=100, butee_d=3000, angle=1000, freq=100, duty=25. Command target=1500 -> state goes to 1 without DEAD (sens was 1 from a prior INC run), pwm 25 high / 75 low. Ramp angle to 1500 -> next edge state=0, pwm=0, at_target=1.
- Start from sens=1, angle=1000, target=500 -> DEAD lasts exactly 50 cycles with pwm=0, then sens=0, state=2.
- target=3500 -> clamped to 3000. Set angle=3000 (butee_d) while driving -> IDLE, limit_hit=1. Next command clears limit_hit.
- butee_g=2000, butee_d=1000 -> cfg_err=1, cmd_ready=0, pwm=0. Separately: enable=0 mid-drive -> pwm=0 next edge, state=0.
- With VERIN_SOFT_START_EN, freq=100, duty=64, RAMP_STEP=16 -> high times 0,16,32,48,64,64 per period. Without the macro: 64 from the first period.

Source files
------------

// File: rtl/verin_ctrl.sv
// rtl/verin_ctrl.sv - closed-loop tiller actuator sequencer (optional soft start: VERIN_SOFT_START_EN)
module verin_ctrl #(
   parameter int ANGLE_W   = 12,
   parameter int PWM_W     = 16,
   parameter int HYST      = 4,
   parameter int DEADTIME  = 50,
   parameter int RAMP_STEP = 16
) (
   input  logic               clk,
   input  logic               raz_n,
   input  logic               enable,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [ANGLE_W-1:0] cmd_target,
   input  logic [ANGLE_W-1:0] angle_barre,
   input  logic [ANGLE_W-1:0] butee_g,
   input  logic [ANGLE_W-1:0] butee_d,
   input  logic [PWM_W-1:0]   freq,
   input  logic [PWM_W-1:0]   duty,
   output logic               pwm,
   output logic               sens,
   output logic               at_target,
   output logic               limit_hit,
   output logic               cfg_err,
   output logic [1:0]         state
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DRIVE_INC = 2'd1,
      DRIVE_DEC = 2'd2,
      DEAD      = 2'd3
   } state_t;

`ifdef VERIN_SOFT_START_EN
   localparam bit SOFT_START = 1'b1;
`else
   localparam bit SOFT_START = 1'b0;
`endif

   localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
   localparam logic [DW-1:0]           DEAD_LAST = DW'(DEADTIME - 1);
   localparam logic signed [ANGLE_W:0] HYST_P    = (ANGLE_W + 1)'(HYST);
   localparam logic signed [ANGLE_W:0] HYST_N    = -HYST_P;

   state_t                  state_q, state_d;
   logic                    sens_q, sens_d;
   logic                    pend_inc_q, pend_inc_d;
   logic                    armed_q, armed_d;
   logic                    limit_q, limit_d;
   logic                    at_target_q, at_target_d;
   logic [ANGLE_W-1:0]      target_q, target_d;
   logic signed [ANGLE_W:0] err_q, err_d;
   logic [PWM_W-1:0]        cnt_q, cnt_d;
   logic [PWM_W-1:0]        freq_q, freq_d;
   logic [PWM_W-1:0]        duty_q, duty_d;
   logic [PWM_W-1:0]        deff_q, deff_d;
   logic [DW-1:0]           dead_q, dead_d;

   logic                    accept;
   logic                    drive_q, drive_d;
   logic                    wrap;
   logic                    want_inc, want_dec;
   logic [ANGLE_W-1:0]      clamped;
   logic [PWM_W:0]          ramp_sum;

   assign cfg_err   = (butee_g >= butee_d);
   assign cmd_ready = raz_n && !cfg_err && (state_q != DEAD);
   assign accept    = cmd_valid && cmd_ready;
   assign clamped   = (cmd_target < butee_g) ? butee_g :
                      (cmd_target > butee_d) ? butee_d : cmd_target;

   // regulation only starts once a target has been received; reset target 0 is not a request
   assign want_inc  = armed_q && (err_q > HYST_P);
   assign want_dec  = armed_q && (err_q < HYST_N);
   assign drive_q   = (state_q == DRIVE_INC) || (state_q == DRIVE_DEC);
   assign drive_d   = (state_d == DRIVE_INC) || (state_d == DRIVE_DEC);

   // err is built from the target being latched this cycle so a new command never sees a stale error
   assign err_d       = $signed({1'b0, target_d}) - $signed({1'b0, angle_barre});
   assign at_target_d = (state_d == IDLE) && armed_d && (err_d <= HYST_P) && (err_d >= HYST_N);

   // sequencer next state: direction choice, end stops, dead-time handling
   always_comb begin
      state_d    = state_q;
      sens_d     = sens_q;
      pend_inc_d = pend_inc_q;
      limit_d    = limit_q;
      target_d   = target_q;
      armed_d    = armed_q;
      dead_d     = '0;
      if (accept) begin
         target_d = clamped;
         armed_d  = 1'b1;
         limit_d  = 1'b0;
      end
      case (state_q)
         IDLE: begin
            if (want_inc) begin
               if (sens_q) begin
                  state_d = DRIVE_INC;
               end else begin
                  state_d    = DEAD;
                  pend_inc_d = 1'b1;
               end
            end else if (want_dec) begin
               if (!sens_q) begin
                  state_d = DRIVE_DEC;
               end else begin
                  state_d    = DEAD;
                  pend_inc_d = 1'b0;
               end
            end
         end
         DRIVE_INC: begin
            if (angle_barre >= butee_d) begin
               state_d = IDLE;
               limit_d = 1'b1;
            end else if (angle_barre >= target_q) begin
               state_d = IDLE;
            end else if (want_dec) begin
               state_d    = DEAD;
               pend_inc_d = 1'b0;
            end
         end
         DRIVE_DEC: begin
            if (angle_barre <= butee_g) begin
               state_d = IDLE;
               limit_d = 1'b1;
            end else if (angle_barre <= target_q) begin
               state_d = IDLE;
            end else if (want_inc) begin
               state_d    = DEAD;
               pend_inc_d = 1'b1;
            end
         end
         default: begin
            if (dead_q == DEAD_LAST) begin
               if (pend_inc_q ? want_inc : want_dec) begin
                  sens_d  = pend_inc_q;
                  state_d = pend_inc_q ? DRIVE_INC : DRIVE_DEC;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               dead_d = dead_q + 1'b1;
            end
         end
      endcase
      if (!enable || cfg_err) begin
         state_d = IDLE;
         sens_d  = sens_q;
      end
   end

   // PWM period counter; freq/duty resampled at entry and at every wrap
   assign wrap     = (freq_q == '0) || (cnt_q == freq_q - 1'b1);
   assign ramp_sum = {1'b0, deff_q} + (PWM_W + 1)'(RAMP_STEP);

   always_comb begin
      cnt_d  = '0;
      freq_d = freq_q;
      duty_d = duty_q;
      deff_d = deff_q;
      if (drive_d && (state_d != state_q)) begin
         freq_d = freq;
         duty_d = duty;
         deff_d = SOFT_START ? '0 : duty;
      end else if (drive_q && drive_d) begin
         if (wrap) begin
            freq_d = freq;
            duty_d = duty;
            deff_d = (SOFT_START && (ramp_sum <= {1'b0, duty})) ? ramp_sum[PWM_W-1:0] : duty;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign pwm       = !cfg_err && drive_q && (freq_q != '0) && (cnt_q < deff_q);
   assign sens      = sens_q;
   assign at_target = at_target_q;
   assign limit_hit = limit_q;
   assign state     = state_q;

   // state and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!raz_n) begin
         state_q     <= IDLE;
         sens_q      <= 1'b0;
         pend_inc_q  <= 1'b0;
         armed_q     <= 1'b0;
         limit_q     <= 1'b0;
         at_target_q <= 1'b0;
         target_q    <= '0;
         err_q       <= '0;
         cnt_q       <= '0;
         freq_q      <= '0;
         duty_q      <= '0;
         deff_q      <= '0;
         dead_q      <= '0;
      end else begin
         state_q     <= state_d;
         sens_q      <= sens_d;
         pend_inc_q  <= pend_inc_d;
         armed_q     <= armed_d;
         limit_q     <= limit_d;
         at_target_q <= at_target_d;
         target_q    <= target_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
         freq_q      <= freq_d;
         duty_q      <= duty_d;
         deff_q      <= deff_d;
         dead_q      <= dead_d;
      end
   end

endmodule
